soc_crc_engine: RTL and testbench

Parametrised multi-bit CRC engine, the successor to the bit-serial CRC32 block.
- CRC width, polynomial, bit order and bits processed per cycle are all generic.
- Accepts a word of 1..DATA_WIDTH/8 valid bytes per valid/ready transfer.
- Adds a synchronous clear.
- Sits behind a SoC peripheral register interface. Default configuration is CRC-32C.

---
 rtl/soc_crc_pkg.sv | 30 +++
 rtl/soc_crc_unroll.sv | 25 ++
 rtl/soc_crc_engine.sv | 93 +++++++++
 tb/tb_soc_crc_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_crc_pkg.sv
// soc_crc_pkg: shared FSM state type and CRC helper functions for the CRC engine.
package soc_crc_pkg;

    localparam int MAX_CRC_WIDTH = 32;

    typedef enum logic {IDLE, SHIFT} state_e;

    function automatic logic [MAX_CRC_WIDTH-1:0] crc_bit_step(
        input logic [MAX_CRC_WIDTH-1:0] crc,
        input logic                     data_bit,
        input logic [MAX_CRC_WIDTH-1:0] poly,
        input int                       width
    );
        logic [MAX_CRC_WIDTH-1:0] mask;
        mask = (width >= MAX_CRC_WIDTH) ? '1 : ((MAX_CRC_WIDTH'(1) << width) - 1'b1);
        return ((crc << 1) ^ ((data_bit ^ crc[width-1]) ? poly : '0)) & mask;
    endfunction

    function automatic logic [MAX_CRC_WIDTH-1:0] reflect(
        input logic [MAX_CRC_WIDTH-1:0] value,
        input int                       width
    );
        logic [MAX_CRC_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CRC_WIDTH; i++)
            if (i < width) r[i] = value[width-1-i];
        return r;
    endfunction

endpackage

// File: rtl/soc_crc_unroll.sv
// soc_crc_unroll: folds BITS_PER_CYCLE data bits into the CRC register combinationally.
module soc_crc_unroll
    import soc_crc_pkg::*;
#(
    parameter int          CRC_WIDTH      = 32,
    parameter logic [31:0] POLYNOMIAL     = 32'h1EDC6F41,
    parameter int          BITS_PER_CYCLE = 8,
    parameter bit          IN_REFLECT     = 1'b1
) (
    input  logic [CRC_WIDTH-1:0]      crc_i,
    input  logic [BITS_PER_CYCLE-1:0] data_i,
    output logic [CRC_WIDTH-1:0]      crc_o
);

    logic [MAX_CRC_WIDTH-1:0] c;

    // Reflected input consumes data_i[0] first, otherwise the top bit goes first.
    always_comb begin
        c = MAX_CRC_WIDTH'(crc_i);
        for (int k = 0; k < BITS_PER_CYCLE; k++)
            c = crc_bit_step(c, data_i[IN_REFLECT ? k : BITS_PER_CYCLE-1-k], POLYNOMIAL, CRC_WIDTH);
        crc_o = c[CRC_WIDTH-1:0];
    end

endmodule

// File: rtl/soc_crc_engine.sv
// soc_crc_engine: parametrised multi-bit CRC engine with valid/ready word input and synchronous clear.
module soc_crc_engine
    import soc_crc_pkg::*;
#(
    parameter int          CRC_WIDTH      = 32,
    parameter logic [31:0] POLYNOMIAL     = 32'h1EDC6F41,
    parameter logic [31:0] INIT           = 32'hFFFFFFFF,
    parameter logic [31:0] FINAL_XOR      = 32'hFFFFFFFF,
    parameter bit          IN_REFLECT     = 1'b1,
    parameter bit          OUT_REFLECT    = 1'b1,
    parameter int          DATA_WIDTH     = 32,
    parameter int          BITS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [((DATA_WIDTH/8 > 1) ? $clog2(DATA_WIDTH/8) : 1)-1:0] in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [CRC_WIDTH-1:0]  out_crc,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)
        || (DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || POLYNOMIAL[0] != 1'b1
        || CRC_WIDTH < 8 || CRC_WIDTH > MAX_CRC_WIDTH) begin : g_param_check
        $error("soc_crc_engine: illegal parameter combination");
    end

    state_e                    state_q, state_d;
    logic [CRC_WIDTH-1:0]      crc_q, crc_d, crc_nxt;
    logic [DATA_WIDTH-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, nbits;
    logic [BITS_PER_CYCLE-1:0] fold_bits;

    assign fold_bits = IN_REFLECT ? buf_q[BITS_PER_CYCLE-1:0] : buf_q[DATA_WIDTH-1 -: BITS_PER_CYCLE];

    soc_crc_unroll #(
        .CRC_WIDTH      (CRC_WIDTH),
        .POLYNOMIAL     (POLYNOMIAL),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .IN_REFLECT     (IN_REFLECT)
    ) u_unroll (
        .crc_i  (crc_q),
        .data_i (fold_bits),
        .crc_o  (crc_nxt)
    );

    assign in_ready = (state_q == IDLE) & ~res & ~clear;
    assign busy     = (state_q == SHIFT) & ~res;
    assign out_crc  = CRC_WIDTH'(OUT_REFLECT ? reflect(MAX_CRC_WIDTH'(crc_q), CRC_WIDTH)
                                             : MAX_CRC_WIDTH'(crc_q)) ^ FINAL_XOR[CRC_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        nbits   = (CNT_W'(in_len) + CNT_W'(1)) << 3;
        if (clear) begin
            state_d = IDLE;
            crc_d   = INIT[CRC_WIDTH-1:0];
        end else if (state_q == SHIFT) begin
            crc_d   = crc_nxt;
            buf_d   = IN_REFLECT ? buf_q >> BITS_PER_CYCLE : buf_q << BITS_PER_CYCLE;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CNT_W'(1)) ? IDLE : SHIFT;
        end else if (in_valid & in_ready) begin
            // MSB-first words are left-aligned so the top valid bit is consumed first.
            buf_d   = IN_REFLECT ? in_data : in_data << (CNT_W'(DATA_WIDTH) - nbits);
            cnt_d   = nbits >> $clog2(BITS_PER_CYCLE);
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            crc_q   <= INIT[CRC_WIDTH-1:0];
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_soc_crc_engine.sv
// tb_soc_crc_engine: four engine configurations checked against a bit-serial message CRC model.
module tb_soc_crc_engine;

    localparam int          WID    [4] = '{32, 32, 32, 16};
    localparam logic [31:0] POLY   [4] = '{32'h1EDC6F41, 32'h04C11DB7, 32'h04C11DB7, 32'h00001021};
    localparam logic [31:0] INI    [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
    localparam logic [31:0] FXR    [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    localparam bit          REFIN  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit          REFOUT [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam int          BPC    [4] = '{8, 8, 1, 4};

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             clear = 1'b0;
    logic [31:0]      in_data = '0;
    logic [1:0]       in_len = '0;
    logic [3:0]       vld = '0, rdy, bsy;
    logic [3:0][31:0] oc;
    logic [31:0]      m_crc [4];
    int               checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign oc[3][31:16] = '0;

    soc_crc_engine u0 (.clk(clk), .res(res), .in_data(in_data), .in_len(in_len), .in_valid(vld[0]),
        .in_ready(rdy[0]), .clear(clear), .out_crc(oc[0]), .busy(bsy[0]));
    soc_crc_engine #(.POLYNOMIAL(32'h04C11DB7)) u1 (.clk(clk), .res(res), .in_data(in_data),
        .in_len(in_len), .in_valid(vld[1]), .in_ready(rdy[1]), .clear(clear), .out_crc(oc[1]), .busy(bsy[1]));
    soc_crc_engine #(.POLYNOMIAL(32'h04C11DB7), .BITS_PER_CYCLE(1)) u2 (.clk(clk), .res(res),
        .in_data(in_data), .in_len(in_len), .in_valid(vld[2]), .in_ready(rdy[2]), .clear(clear),
        .out_crc(oc[2]), .busy(bsy[2]));
    soc_crc_engine #(.CRC_WIDTH(16), .POLYNOMIAL(32'h1021), .INIT(32'hFFFF), .FINAL_XOR(32'h0),
        .IN_REFLECT(1'b0), .OUT_REFLECT(1'b0), .BITS_PER_CYCLE(4)) u3 (.clk(clk), .res(res),
        .in_data(in_data), .in_len(in_len), .in_valid(vld[3]), .in_ready(rdy[3]), .clear(clear),
        .out_crc(oc[3][15:0]), .busy(bsy[3]));

    // Message-level model: walks every valid bit of the word in wire order, one bit at a time.
    function automatic logic [31:0] m_fold(int i, logic [31:0] c, logic [31:0] d, int len);
        int          nb;
        logic        b;
        logic [31:0] mask;
        nb   = 8 * (len + 1);
        mask = (WID[i] == 32) ? 32'hFFFFFFFF : ((32'h1 << WID[i]) - 1);
        for (int k = 0; k < nb; k++) begin
            b = REFIN[i] ? d[k] : d[nb-1-k];
            c = ((c << 1) ^ ((b ^ c[WID[i]-1]) ? POLY[i] : 32'h0)) & mask;
        end
        return c;
    endfunction

    function automatic logic [31:0] m_out(int i);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < WID[i]; k++) r[k] = REFOUT[i] ? m_crc[i][WID[i]-1-k] : m_crc[i][k];
        return r ^ FXR[i];
    endfunction

    task automatic model_init();
        for (int k = 0; k < 4; k++) m_crc[k] = INI[k];
    endtask

    task automatic send_word(input int i, input logic [31:0] d, input int len, output int low, output int bc);
        int t;
        t = 0;
        while (!rdy[i] && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!rdy[i]) begin errors++; $display("FAIL ready_wait dut%0d: in_ready=%b, required 1", i, rdy[i]); end
        in_data = d; in_len = 2'(len); vld[i] = 1'b1;
        m_crc[i] = m_fold(i, m_crc[i], d, len);
        @(negedge clk);
        vld[i] = 1'b0; in_data = $urandom; in_len = 2'($urandom_range(0, 3));
        low = 0; bc = 0;
        while (!rdy[i] && low < 100) begin low++; bc += int'(bsy[i]); @(negedge clk); end
    endtask

    task automatic check_out(input int i, input string name);
        checks++;
        if (oc[i] !== m_out(i)) begin
            errors++; $display("FAIL %s dut%0d: out_crc=%h, required %h", name, i, oc[i], m_out(i));
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (rdy !== 4'h0) begin errors++; $display("FAIL reset_ready_early: in_ready=%b, required 0000", rdy); end
        @(negedge clk);
        model_init();
        checks++;
        if (rdy !== 4'h0 || bsy !== 4'h0) begin
            errors++; $display("FAIL reset_hold: in_ready=%b busy=%b, required 0000/0000", rdy, bsy);
        end
        for (int k = 0; k < 4; k++) check_out(k, "reset_out");
        checks++;
        if (oc[0] !== 32'h0) begin errors++; $display("FAIL reset_out_const: out_crc=%h, required 00000000", oc[0]); end
        @(negedge clk);
        res = 1'b0;
        #1;
        checks++;
        if (rdy !== 4'hF) begin errors++; $display("FAIL reset_release: in_ready=%b, required 1111", rdy); end
    endtask

    task automatic test_single_bytes();
        string s;
        int    low, bc;
        s = "123456789";
        for (int n = 0; n < 9; n++) begin
            send_word(0, {24'hA5A5A5, s[n]}, 0, low, bc);
            checks++;
            if (low != 1) begin errors++; $display("FAIL byte_latency byte%0d: ready low %0d cycles, required 1", n, low); end
        end
        check_out(0, "bytes_model");
        checks++;
        if (oc[0] !== 32'hE3069283) begin errors++; $display("FAIL bytes_const: out_crc=%h, required e3069283", oc[0]); end
    endtask

    task automatic test_words();
        logic [31:0] wr [3], wn [3];
        int          ln [3];
        logic [31:0] kv [4];
        int          low, bc;
        wr = '{32'h34333231, 32'h38373635, 32'h00000039};
        wn = '{32'h31323334, 32'h35363738, 32'h00000039};
        ln = '{3, 3, 0};
        kv = '{32'hE3069283, 32'hCBF43926, 32'hCBF43926, 32'h000029B1};
        @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0; model_init();
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 3; w++) begin
                send_word(i, REFIN[i] ? wr[w] : wn[w], ln[w], low, bc);
                checks++;
                if (low != 8 * (ln[w] + 1) / BPC[i] || bc != low) begin
                    errors++;
                    $display("FAIL word_latency dut%0d word%0d: ready low %0d busy %0d, required %0d", i, w, low, bc,
                             8 * (ln[w] + 1) / BPC[i]);
                end
            end
            check_out(i, "words_model");
            checks++;
            if (oc[i] !== kv[i]) begin errors++; $display("FAIL words_const dut%0d: out_crc=%h, required %h", i, oc[i], kv[i]); end
        end
    endtask

    task automatic test_clear_mid();
        int low, bc;
        string s;
        s = "123456789";
        while (!rdy[0]) @(negedge clk);
        in_data = 32'h34333231; in_len = 2'd3; vld[0] = 1'b1;
        @(negedge clk); vld[0] = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; model_init();
        #1;
        checks++;
        if (bsy[0] !== 1'b0 || oc[0] !== 32'h0 || rdy[0] !== 1'b1) begin
            errors++; $display("FAIL clear_mid: busy=%b out_crc=%h in_ready=%b, required 0/00000000/1", bsy[0], oc[0], rdy[0]);
        end
        for (int n = 0; n < 9; n++) send_word(0, {24'h0, s[n]}, 0, low, bc);
        checks++;
        if (oc[0] !== 32'hE3069283) begin errors++; $display("FAIL clear_then_msg: out_crc=%h, required e3069283", oc[0]); end
    endtask

    task automatic test_clear_valid();
        int low, bc;
        send_word(1, 32'h12345678, 3, low, bc);
        clear = 1'b1; in_data = 32'hDEADBEEF; in_len = 2'd3; vld[1] = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 1'b0) begin errors++; $display("FAIL clear_valid_ready: in_ready=%b, required 0", rdy[1]); end
        @(negedge clk); clear = 1'b0; vld[1] = 1'b0; model_init();
        #1;
        checks++;
        if (bsy[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            errors++; $display("FAIL clear_valid_accept: busy=%b in_ready=%b, required 0/1", bsy[1], rdy[1]);
        end
        check_out(1, "clear_valid_init");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          t;
        d = $urandom;
        while (!rdy[0]) @(negedge clk);
        in_data = d; in_len = 2'd3; vld[0] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            m_crc[0] = m_fold(0, m_crc[0], d, 3);
            @(negedge clk);
            in_data = $urandom;
            t = 1;
            while (!rdy[0] && t < 50) begin @(negedge clk); t++; end
            checks++;
            if (t != 5) begin errors++; $display("FAIL b2b_period word%0d: %0d cycles, required 5", w, t); end
            d = $urandom; in_data = d;
        end
        vld[0] = 1'b0;
        check_out(0, "b2b_model");
    endtask

    task automatic test_random();
        int i, len, low, bc;
        for (int n = 0; n < 40; n++) begin
            i = $urandom_range(0, 3); len = $urandom_range(0, 3);
            send_word(i, $urandom, len, low, bc);
            checks++;
            if (low != 8 * (len + 1) / BPC[i]) begin
                errors++; $display("FAIL rand_latency dut%0d: ready low %0d, required %0d", i, low, 8 * (len + 1) / BPC[i]);
            end
            check_out(i, "rand_model");
            if ($urandom_range(0, 9) == 0) begin
                clear = 1'b1; @(negedge clk); clear = 1'b0; model_init();
                #1 check_out(i, "rand_clear");
            end
        end
    endtask

    task automatic test_reset_mid();
        while (!rdy[2]) @(negedge clk);
        in_data = $urandom; in_len = 2'd3; vld[2] = 1'b1;
        @(negedge clk); vld[2] = 1'b0;
        @(negedge clk); @(negedge clk);
        res = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'h0) begin errors++; $display("FAIL reset_mid_ready: in_ready=%b, required 0000", rdy); end
        @(negedge clk);
        model_init();
        checks++;
        if (bsy !== 4'h0 || rdy !== 4'h0) begin
            errors++; $display("FAIL reset_mid_state: busy=%b in_ready=%b, required 0000/0000", bsy, rdy);
        end
        for (int k = 0; k < 4; k++) check_out(k, "reset_mid_out");
        @(negedge clk);
        res = 1'b0;
        #1;
        checks++;
        if (rdy !== 4'hF || bsy !== 4'h0) begin
            errors++; $display("FAIL reset_mid_release: in_ready=%b busy=%b, required 1111/0000", rdy, bsy);
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_single_bytes();
        test_words();
        test_clear_mid();
        test_clear_valid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
